// File: rtl/pwm_generator_multi.sv
// rtl/pwm_generator_multi.sv - multi-channel frame-synchronous PWM generator with debounced duty buttons
module pwm_generator_multi #(
    parameter int CHANNELS    = 4,
    parameter int WIDTH       = 8,
    parameter int STEP        = 10,
    parameter int DEBOUNCE    = 4,
    parameter int PERIOD_INIT = 100,
    parameter int DUTY_INIT   = 50
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       increment,
    input  logic [CHANNELS-1:0]       decrement,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center_mode,
    output logic [CHANNELS-1:0]       pwm_out,
    output logic                      frame_start,
    output logic [CHANNELS*WIDTH-1:0] duty_q
);
    // Increment buttons occupy the low half of the button vector, decrement the high half
    localparam int               NB      = 2 * CHANNELS;
    localparam int               DBW     = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [DBW-1:0]   DB_LAST = DBW'(DEBOUNCE - 1);
    localparam logic [WIDTH:0]   STEP_W  = (WIDTH + 1)'(STEP);
    localparam logic [WIDTH-1:0] P_INIT  = WIDTH'(PERIOD_INIT);
    localparam logic [WIDTH-1:0] D_INIT  = WIDTH'(DUTY_INIT);

    logic [NB-1:0]       btn_raw;
    logic [NB-1:0]       sync1_q, sync2_q;
    logic [NB-1:0]       stable_q, stable_d, stable_prev_q;
    logic [NB-1:0]       rise;
    logic [DBW-1:0]      db_cnt_q [NB];
    logic [DBW-1:0]      db_cnt_d [NB];
    logic [CHANNELS-1:0] inc_rise, dec_rise;

    logic [WIDTH-1:0]    cnt_q, cnt_d;
    logic                dir_q, dir_d;
    logic [WIDTH-1:0]    p_act_q, p_new, p_last;
    logic                mode_q;
    logic                boundary;

    logic [CHANNELS*WIDTH-1:0] duty_d, duty_act_q, duty_act_d;
    logic [WIDTH:0]            cur     [CHANNELS];
    logic [WIDTH:0]            stepped [CHANNELS];

    assign btn_raw  = {decrement, increment};
    assign rise     = stable_q & ~stable_prev_q;
    assign inc_rise = rise[CHANNELS-1:0];
    assign dec_rise = rise[NB-1:CHANNELS];

    // Periods below 2 would collapse the up/down turn, so they are raised to 2
    assign p_new  = (period < WIDTH'(2)) ? WIDTH'(2) : period;
    assign p_last = p_act_q - WIDTH'(1);

    // Debounce: accepted level flips after DEBOUNCE consecutive disagreeing samples
    always_comb begin
        stable_d = stable_q;
        for (int b = 0; b < NB; b++) begin
            db_cnt_d[b] = '0;
            if (sync2_q[b] != stable_q[b]) begin
                if (db_cnt_q[b] == DB_LAST) begin
                    stable_d[b] = ~stable_q[b];
                end else begin
                    db_cnt_d[b] = db_cnt_q[b] + DBW'(1);
                end
            end
        end
    end

    // Button synchronizers, debounce counters and previous accepted level for edge detect
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '0;
            sync2_q       <= '0;
            stable_q      <= '0;
            stable_prev_q <= '0;
            for (int b = 0; b < NB; b++) db_cnt_q[b] <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            for (int b = 0; b < NB; b++) db_cnt_q[b] <= db_cnt_d[b];
        end
    end

    // Frame counter: edge mode wraps, centre mode holds each turn value for one extra cycle
    always_comb begin
        cnt_d    = cnt_q;
        dir_d    = dir_q;
        boundary = 1'b0;
        if (!mode_q) begin
            dir_d = 1'b0;
            if (cnt_q == p_last) begin
                cnt_d    = '0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end else if (!dir_q) begin
            if (cnt_q == p_last) dir_d = 1'b1;
            else                 cnt_d = cnt_q + WIDTH'(1);
        end else begin
            if (cnt_q == '0) begin
                dir_d    = 1'b0;
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end
    end

    // Counter state plus period/mode shadows that only change on a frame boundary
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            p_act_q <= P_INIT;
            mode_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            dir_q <= dir_d;
            if (boundary) begin
                p_act_q <= p_new;
                mode_q  <= center_mode;
            end
        end
    end

    // Saturating duty steps; boundary clamps both the live and shadow duty to the new period
    always_comb begin
        duty_d     = duty_q;
        duty_act_d = duty_act_q;
        for (int i = 0; i < CHANNELS; i++) begin
            cur[i]     = {1'b0, duty_q[i*WIDTH +: WIDTH]};
            stepped[i] = cur[i];
            if (inc_rise[i] && !dec_rise[i]) begin
                if (cur[i] + STEP_W > {1'b0, p_act_q}) stepped[i] = {1'b0, p_act_q};
                else                                   stepped[i] = cur[i] + STEP_W;
            end else if (dec_rise[i] && !inc_rise[i]) begin
                if (cur[i] < STEP_W) stepped[i] = '0;
                else                 stepped[i] = cur[i] - STEP_W;
            end
            if (boundary) begin
                if (stepped[i] > {1'b0, p_new}) stepped[i] = {1'b0, p_new};
                if (cur[i] > {1'b0, p_new}) duty_act_d[i*WIDTH +: WIDTH] = p_new;
                else                        duty_act_d[i*WIDTH +: WIDTH] = duty_q[i*WIDTH +: WIDTH];
            end
            duty_d[i*WIDTH +: WIDTH] = stepped[i][WIDTH-1:0];
        end
    end

    // Live and shadow duty registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            duty_q     <= {CHANNELS{D_INIT}};
            duty_act_q <= {CHANNELS{D_INIT}};
        end else begin
            duty_q     <= duty_d;
            duty_act_q <= duty_act_d;
        end
    end

    // Registered outputs: compare against the shadow duty, flag the first up-count cycle
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pwm_out     <= '0;
            frame_start <= 1'b0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                pwm_out[i] <= (cnt_q < duty_act_q[i*WIDTH +: WIDTH]);
            end
            frame_start <= (cnt_q == '0) && !dir_q;
        end
    end

endmodule

// File: tb/tb_pwm_generator_multi.sv
// tb/tb_pwm_generator_multi.sv - self-checking bench for pwm_generator_multi
module tb_pwm_generator_multi;
    localparam int CH   = 2;
    localparam int W    = 8;
    localparam int STEP = 10;
    localparam int DB   = 4;
    localparam int PI   = 100;
    localparam int DI   = 50;

    logic              clock = 1'b0;
    logic              reset;
    logic [CH-1:0]     increment, decrement;
    logic [W-1:0]      period;
    logic              center_mode;
    logic [CH-1:0]     pwm_out;
    logic              frame_start;
    logic [CH*W-1:0]   duty_q;

    int tests  = 0;
    int failed = 0;

    pwm_generator_multi #(
        .CHANNELS(CH), .WIDTH(W), .STEP(STEP), .DEBOUNCE(DB),
        .PERIOD_INIT(PI), .DUTY_INIT(DI)
    ) dut (
        .clock(clock), .reset(reset), .increment(increment), .decrement(decrement),
        .period(period), .center_mode(center_mode), .pwm_out(pwm_out),
        .frame_start(frame_start), .duty_q(duty_q)
    );

    always #5 clock = ~clock;

    // Reference model: position inside the frame, accepted button levels from raw sample history
    int          m_pos, m_flen, m_p, m_mode;
    int          m_duty [CH];
    int          m_dact [CH];
    logic [31:0] h_inc [CH];
    logic [31:0] h_dec [CH];
    bit          st_inc [CH];
    bit          st_dec [CH];
    bit          pd_inc [CH];
    bit          pd_dec [CH];
    logic [CH-1:0] e_pwm;
    bit          e_fs;

    localparam logic [31:0] WMASK = (32'd1 << DB) - 32'd1;

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic bit level(int pos, int d, int p, int mode);
        if (mode == 0) return pos < d;
        return (pos < d) || (pos >= 2 * p - d);
    endfunction

    // Last DEBOUNCE synchronized samples (raw two edges ago and older) all equal v
    function automatic bit window_is(logic [31:0] h, bit v);
        logic [31:0] w;
        w = (h >> 2) & WMASK;
        return v ? (w == WMASK) : (w == 32'd0);
    endfunction

    task automatic model_reset();
        m_pos = 0; m_p = PI; m_mode = 0; m_flen = PI;
        for (int c = 0; c < CH; c++) begin
            m_duty[c] = DI; m_dact[c] = DI;
            h_inc[c] = '0; h_dec[c] = '0;
            st_inc[c] = 0; st_dec[c] = 0; pd_inc[c] = 0; pd_dec[c] = 0;
        end
        e_pwm = '0; e_fs = 0;
    endtask

    task automatic model_edge();
        int old_duty [CH];
        int pnew;
        for (int c = 0; c < CH; c++) e_pwm[c] = level(m_pos, m_dact[c], m_p, m_mode);
        e_fs = (m_pos == 0);
        for (int c = 0; c < CH; c++) begin
            old_duty[c] = m_duty[c];
            if (pd_inc[c] && !pd_dec[c])
                m_duty[c] = (m_duty[c] + STEP > m_p) ? m_p : m_duty[c] + STEP;
            else if (pd_dec[c] && !pd_inc[c])
                m_duty[c] = (m_duty[c] < STEP) ? 0 : m_duty[c] - STEP;
        end
        for (int c = 0; c < CH; c++) begin
            h_inc[c] = {h_inc[c][30:0], increment[c]};
            h_dec[c] = {h_dec[c][30:0], decrement[c]};
            pd_inc[c] = 0;
            pd_dec[c] = 0;
            if (!st_inc[c] && window_is(h_inc[c], 1'b1)) begin st_inc[c] = 1; pd_inc[c] = 1; end
            else if (st_inc[c] && window_is(h_inc[c], 1'b0)) st_inc[c] = 0;
            if (!st_dec[c] && window_is(h_dec[c], 1'b1)) begin st_dec[c] = 1; pd_dec[c] = 1; end
            else if (st_dec[c] && window_is(h_dec[c], 1'b0)) st_dec[c] = 0;
        end
        if (m_pos == m_flen - 1) begin
            pnew   = (int'(period) < 2) ? 2 : int'(period);
            m_p    = pnew;
            m_mode = int'(center_mode);
            m_flen = (m_mode != 0) ? 2 * pnew : pnew;
            for (int c = 0; c < CH; c++) begin
                m_dact[c] = (old_duty[c] > pnew) ? pnew : old_duty[c];
                if (m_duty[c] > pnew) m_duty[c] = pnew;
            end
            m_pos = 0;
        end else begin
            m_pos++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
        check("pwm_out", int'(pwm_out), int'(e_pwm));
        check("frame_start", int'(frame_start), int'(e_fs));
        for (int c = 0; c < CH; c++) check("duty_q", int'(duty_q[c*W +: W]), m_duty[c]);
    endtask

    task automatic press(input logic [CH-1:0] inc, input logic [CH-1:0] dec, input int hold, input int gap);
        increment = inc;
        decrement = dec;
        repeat (hold) tick();
        increment = '0;
        decrement = '0;
        repeat (gap) tick();
    endtask

    // Counts high cycles of one channel between consecutive frame_start pulses
    task automatic measure_frame(input int ch, output int highs, output int len);
        int guard;
        highs = 0;
        len   = 0;
        guard = 0;
        tick();
        while (!frame_start && guard < 1200) begin tick(); guard++; end
        if (!frame_start) begin check("frame_start_timeout", 0, 1); return; end
        highs = int'(pwm_out[ch]);
        len   = 1;
        guard = 0;
        tick();
        while (!frame_start && guard < 1200) begin
            highs += int'(pwm_out[ch]);
            len++;
            tick();
            guard++;
        end
        if (!frame_start) check("frame_end_timeout", 0, 1);
    endtask

    task automatic sync_mid_frame();
        int guard;
        guard = 0;
        tick();
        while (!frame_start && guard < 1200) begin tick(); guard++; end
        if (!frame_start) check("mid_frame_timeout", 0, 1);
        repeat (10) tick();
    endtask

    typedef struct {
        logic [CH-1:0] inc;
        logic [CH-1:0] dec;
        int            hold;
        int            exp0;
        int            exp1;
        int            chk_ch;
        int            chk_high;
    } vec_t;

    vec_t tbl[$];
    int   plist [10] = '{0, 1, 2, 3, 5, 10, 17, 40, 100, 255};

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int h, l, cnt;

        tbl.push_back(vec_t'{2'b01, 2'b00, 1, 60, 50, 0, 60});
        for (int k = 1; k <= 6; k++)
            tbl.push_back(vec_t'{2'b10, 2'b00, 6, 60, (k <= 5) ? 50 + 10 * k : 100, (k == 6) ? 1 : -1, 100});
        for (int k = 1; k <= 11; k++)
            tbl.push_back(vec_t'{2'b00, 2'b10, 6, 60, (k <= 10) ? 100 - 10 * k : 0, (k == 11) ? 1 : -1, 0});
        tbl.push_back(vec_t'{2'b01, 2'b01, 6, 60, 0, -1, 0});
        tbl.push_back(vec_t'{2'b00, 2'b01, DB, 50, 0, -1, 0});
        tbl.push_back(vec_t'{2'b01, 2'b00, DB - 1, 50, 0, 0, 50});
        tbl.push_back(vec_t'{2'b11, 2'b00, 6, 60, 10, -1, 0});

        reset = 1'b0; increment = '0; decrement = '0; period = W'(PI); center_mode = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset_pwm", int'(pwm_out), 0);
        check("reset_fs", int'(frame_start), 0);
        check("reset_duty", int'(duty_q), DI * 257);
        @(negedge clock);
        reset = 1'b1;

        // Default frame after release
        measure_frame(0, h, l);
        check("init_high0", h, DI);
        check("init_len", l, PI);

        // Press latency, counting the sampling edge itself
        increment = 2'b01;
        cnt = 0;
        while (int'(duty_q[W-1:0]) == DI && cnt < 20) begin tick(); cnt++; end
        check("inc_latency_edges", cnt, DB + 3);
        check("inc_latency_value", int'(duty_q[W-1:0]), 60);
        increment = '0;
        repeat (12) tick();

        for (int i = 0; i < tbl.size(); i++) begin
            press(tbl[i].inc, tbl[i].dec, tbl[i].hold, 12);
            check("tbl_duty0", int'(duty_q[W-1:0]), tbl[i].exp0);
            check("tbl_duty1", int'(duty_q[2*W-1:W]), tbl[i].exp1);
            if (tbl[i].chk_ch >= 0) begin
                measure_frame(tbl[i].chk_ch, h, l);
                check("tbl_frame_high", h, tbl[i].chk_high);
                check("tbl_frame_len", l, PI);
            end
        end

        // Centre mode with duty 30: 60 high cycles in a 200-cycle frame
        repeat (3) press(2'b00, 2'b01, 6, 12);
        check("pre_centre_duty", int'(duty_q[W-1:0]), 30);
        sync_mid_frame();
        center_mode = 1'b1;
        measure_frame(0, h, l);
        check("centre_high", h, 60);
        check("centre_len", l, 200);

        // Shrink period below duty 60: clamped to 40, constantly high
        repeat (3) press(2'b01, 2'b00, 6, 12);
        check("pre_clamp_duty", int'(duty_q[W-1:0]), 60);
        sync_mid_frame();
        period = W'(40);
        measure_frame(0, h, l);
        check("clamp_high", h, 80);
        check("clamp_len", l, 80);
        check("clamp_duty", int'(duty_q[W-1:0]), 40);
        check("clamp_duty1", int'(duty_q[2*W-1:W]), 10);

        // Asynchronous reset while the output is high
        period = W'(PI);
        center_mode = 1'b0;
        cnt = 0;
        while (!pwm_out[0] && cnt < 500) begin tick(); cnt++; end
        check("pwm_high_before_reset", int'(pwm_out[0]), 1);
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_pwm", int'(pwm_out), 0);
        check("async_reset_fs", int'(frame_start), 0);
        check("async_reset_duty", int'(duty_q), DI * 257);
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        measure_frame(1, h, l);
        check("post_reset_high", h, DI);
        check("post_reset_len", l, PI);

        // Randomized presses, period and mode changes against the model
        for (int it = 0; it < 250; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4, 5:
                    press(CH'($urandom_range(0, 3)), CH'($urandom_range(0, 3)),
                          int'($urandom_range(1, 8)), int'($urandom_range(0, 10)));
                6, 7: begin period = W'(plist[$urandom_range(0, 9)]); tick(); end
                8:    begin center_mode = ~center_mode; tick(); end
                default: repeat ($urandom_range(1, 300)) tick();
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/pwm_generator_multi.md
# pwm_generator_multi

Multi-channel successor to the single-channel PWM generator. One shared frame counter drives CHANNELS PWM outputs, each with its own debounced increment/decrement button pair and saturating duty register. Adds a runtime period, an edge- or centre-aligned mode, and glitch-free duty/period/mode updates at frame boundaries. It sits between the board push-buttons and the power-stage/LED drivers.

## Interface
- CHANNELS, 4, number of independent PWM channels (≥1)
- WIDTH, 8, counter/duty/period width in bits
- STEP, 10, duty change per accepted button press, in counts
- DEBOUNCE, 4, consecutive stable cycles required to accept a button level change (≥1)
- PERIOD_INIT, 100, period loaded at reset
- DUTY_INIT, 50, per-channel duty loaded at reset (≤ PERIOD_INIT)

Ports:
- clock  in  1  single system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- increment  in  CHANNELS  raw async button, bit i raises channel i duty
- decrement  in  CHANNELS  raw async button, bit i lowers channel i duty
- period  in  WIDTH  frame period in counts; values <2 treated as 2
- center_mode  in  1  0 = edge-aligned, 1 = centre-aligned
- pwm_out  out  CHANNELS  registered PWM outputs
- frame_start  out  1  one-cycle pulse on the first cycle of each frame
- duty_q  out  CHANNELS*WIDTH  current duty registers, channel i at bits [i*WIDTH +: WIDTH]

## Operation
- Button path per bit: 2-FF synchronizer → debouncer → rising-edge detect. Debouncer: stable level flips only after the synchronized value differs from it for DEBOUNCE consecutive cycles. A press yields exactly one step regardless of hold length; no auto-repeat. Presses shorter than DEBOUNCE cycles are ignored.
- Duty update per channel, computed in WIDTH+1 bits: inc edge → duty = min(duty+STEP, P_act); dec edge → duty = max(duty−STEP, 0). Inc and dec edges in the same cycle → no change.
- Shadow set {P_act, mode_act, duty_act[i]} loads only on the frame-boundary edge. P_act = max(period, 2). At that edge, any duty register above the new P_act is also clamped to P_act.
- Edge mode: cnt counts 0..P_act−1 and wraps. Frame = P_act cycles. pwm_out[i] = (cnt < duty_act[i]).
- Centre mode: cnt runs up 0..P_act−1, then down P_act−1..0; each turn value is repeated once. Frame = 2·P_act cycles. pwm_out[i] = (cnt < duty_act[i]), giving 2·duty_act high cycles centred on the cnt=0 turn.
- Frame boundary: the edge that puts cnt at 0 to start a new frame, i.e. the edge-mode wrap or the centre-mode down-to-up turn.
- Duty 0 → output constantly low. Duty = P_act → output constantly high; no glitch pulses in either case.

## Timing
- Reset asserted (asynchronous): pwm_out=0, frame_start=0, cnt=0, direction=up, P_act=PERIOD_INIT, mode_act=0, duty and duty_act = DUTY_INIT, debouncers stable low with counters at 0.
- First edge after reset release: cnt=0 frame begins. frame_start and pwm_out reflect it one cycle later.
- pwm_out and frame_start are registered: 1 cycle after the cnt value that produced them.
- Button latency: duty_q changes on the (DEBOUNCE+2)th rising edge after the edge that first samples the input high. Release is debounced identically and produces no step.
- New duty/period/mode reaches pwm_out in the first frame that starts after duty_q changes. A frame in progress is never altered.
- Reset mid-frame: outputs drop to 0 immediately, without waiting for a clock edge.

## Test plan
Defaults apply, with CHANNELS=2, period=100.
- Reset release, edge mode, no presses → both channels 50 high / 50 low per 100-cycle frame; frame_start pulses every 100 cycles.
- ch0 increment held 6 cycles → duty_q[0] = 60 after DEBOUNCE+2 edges, 60 high from the next frame. A 1-cycle increment pulse → duty_q unchanged.
- Six ch1 increments → duty saturates at 100 and pwm_out[1] is constantly high. Eleven decrements → 0, constantly low, no glitch at frame boundaries.
- ch0 inc and dec held together for 6 cycles → duty_q[0] stays 50.
- center_mode=1 set mid-frame, duty 30 → current frame finishes edge-aligned, then 60-cycle high pulse per 200-cycle frame, centred on frame_start. period changed to 40 with duty 60 → duty clamped to 40, output constantly high.
- Reset asserted mid-frame while pwm_out=1 → pwm_out=0 before the next edge. After release → DUTY_INIT and PERIOD_INIT restored.
